branch_ctrl: RTL and testbench

BRANCH_CTRL -- requirements
Module: branch_ctrl

---
 rtl/branch_ctrl_if.sv | 32 +++
 rtl/branch_ctrl.sv | 126 ++++++++++++
 tb/tb_branch_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/branch_ctrl_if.sv
// ID-stage branch hazard/resolution bus between the pipeline and branch_ctrl.
// The slave side is the controller; the master side is the pipeline (or bench).
interface branch_ctrl_if;
  logic        start_i;
  logic [3:0]  op_i;
  logic [4:0]  rs_i;
  logic [4:0]  rt_i;
  logic [4:0]  ex_rd_i;
  logic        ex_regwrite_i;
  logic        ex_memread_i;
  logic [4:0]  mem_rd_i;
  logic        mem_memread_i;
  logic        eq_i;
  logic        stall_o;
  logic        bubble_o;
  logic        flush_o;
  logic        pc_sel_o;
  logic [15:0] branch_cnt_o;
  logic [15:0] taken_cnt_o;

  modport slave (
    input  start_i, op_i, rs_i, rt_i, ex_rd_i, ex_regwrite_i, ex_memread_i,
           mem_rd_i, mem_memread_i, eq_i,
    output stall_o, bubble_o, flush_o, pc_sel_o, branch_cnt_o, taken_cnt_o
  );

  modport master (
    output start_i, op_i, rs_i, rt_i, ex_rd_i, ex_regwrite_i, ex_memread_i,
           mem_rd_i, mem_memread_i, eq_i,
    input  stall_o, bubble_o, flush_o, pc_sel_o, branch_cnt_o, taken_cnt_o
  );
endinterface

// File: rtl/branch_ctrl.sv
// ID-stage branch controller: detects data hazards on branch operands, stalls,
// resolves the branch in ID and keeps saturating resolved/taken counters.
module branch_ctrl (
  input  logic       clk_i,
  input  logic       rst_i,
  branch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WAIT2 = 2'd2,
    WAIT1 = 2'd3
  } state_e;

  localparam logic [3:0] OP_BEQ = 4'b0111;

  state_e      state_q, state_d;
  logic [15:0] branch_cnt_q, branch_cnt_d;
  logic [15:0] taken_cnt_q, taken_cnt_d;

  logic br_s, match_ex_s, match_mem_s, load_hz_s, alu_hz_s, resolve_s;
  logic stall_s, bubble_s, flush_s, pc_sel_s;

  function automatic logic reg_match(input logic [4:0] r, input logic [4:0] rs,
                                     input logic [4:0] rt);
    reg_match = (r != 5'd0) && ((r == rs) || (r == rt));
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

  // Hazard classification of the instruction currently in ID
  always_comb begin
    br_s        = (bus.op_i == OP_BEQ);
    match_ex_s  = reg_match(bus.ex_rd_i, bus.rs_i, bus.rt_i);
    match_mem_s = reg_match(bus.mem_rd_i, bus.rs_i, bus.rt_i);
    load_hz_s   = br_s && bus.ex_memread_i && match_ex_s;
    alu_hz_s    = br_s && ((bus.ex_regwrite_i && !bus.ex_memread_i && match_ex_s) ||
                           (bus.mem_memread_i && match_mem_s));
  end

  // Next-state and Mealy outputs; the resolve outputs follow eq_i in-cycle
  always_comb begin
    state_d   = state_q;
    stall_s   = 1'b0;
    bubble_s  = 1'b0;
    flush_s   = 1'b0;
    pc_sel_s  = 1'b0;
    resolve_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) state_d = RUN;
        else             state_d = IDLE;
      end
      RUN: begin
        // A load in EX needs two bubbles, so it wins over the one-cycle cases
        if (load_hz_s) begin
          stall_s  = 1'b1;
          bubble_s = 1'b1;
          state_d  = WAIT1;
        end else if (alu_hz_s) begin
          stall_s  = 1'b1;
          bubble_s = 1'b1;
          state_d  = RUN;
        end else if (br_s) begin
          flush_s   = bus.eq_i;
          pc_sel_s  = bus.eq_i;
          resolve_s = 1'b1;
          state_d   = RUN;
        end else begin
          state_d = RUN;
        end
      end
      WAIT2: begin
        stall_s  = 1'b1;
        bubble_s = 1'b1;
        state_d  = WAIT1;
      end
      WAIT1: begin
        stall_s  = 1'b1;
        bubble_s = 1'b1;
        state_d  = RUN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Counter next values, updated only on a resolve edge
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    if (resolve_s) begin
      branch_cnt_d = sat_inc(branch_cnt_q);
      if (bus.eq_i) taken_cnt_d = sat_inc(taken_cnt_q);
      else          taken_cnt_d = taken_cnt_q;
    end else begin
      branch_cnt_d = branch_cnt_q;
      taken_cnt_d  = taken_cnt_q;
    end
  end

  // State and counter registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      branch_cnt_q <= 16'd0;
      taken_cnt_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign bus.stall_o      = stall_s;
  assign bus.bubble_o     = bubble_s;
  assign bus.flush_o      = flush_s;
  assign bus.pc_sel_o     = pc_sel_s;
  assign bus.branch_cnt_o = branch_cnt_q;
  assign bus.taken_cnt_o  = taken_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: a vector table for single-cycle RUN behaviour
// plus hand-written multi-cycle sequences for stalls, reset and saturation.
module tb_branch_ctrl;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   total = 0;
  int   bad   = 0;

  branch_ctrl_if bif ();

  branch_ctrl dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bif.slave)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs, rt, ex_rd;
    logic        ex_rw, ex_mr;
    logic [4:0]  mem_rd;
    logic        mem_mr, eq;
    logic [3:0]  exp_o;   // {stall, bubble, flush, pc_sel}
    logic [15:0] exp_b, exp_t;
  } vec_t;

  vec_t tbl [10];

  function automatic logic [3:0] outs();
    outs = {bif.stall_o, bif.bubble_o, bif.flush_o, bif.pc_sel_o};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] ex_rd, input logic ex_rw, input logic ex_mr,
                        input logic [4:0] mem_rd, input logic mem_mr, input logic eq);
    bif.op_i = op; bif.rs_i = rs; bif.rt_i = rt;
    bif.ex_rd_i = ex_rd; bif.ex_regwrite_i = ex_rw; bif.ex_memread_i = ex_mr;
    bif.mem_rd_i = mem_rd; bif.mem_memread_i = mem_mr; bif.eq_i = eq;
  endtask

  // Called at posedge+1: check outputs mid-cycle, then advance to next posedge+1
  task automatic cyc_chk(input string nm, input logic [3:0] exp_o);
    #3;
    chk(nm, {12'd0, outs()}, {12'd0, exp_o});
    @(posedge clk_i);
    #1;
  endtask

  task automatic cnt_chk(input string nm, input logic [15:0] eb, input logic [15:0] et);
    chk({nm, "_bcnt"}, bif.branch_cnt_o, eb);
    chk({nm, "_tcnt"}, bif.taken_cnt_o, et);
  endtask

  task automatic start_run();
    bif.start_i = 1'b1;
    @(posedge clk_i);
    #1;
    bif.start_i = 1'b0;
  endtask

  initial begin
    tbl[0] = '{4'b0000, 5'd5, 5'd1, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 4'b0000, 16'd0, 16'd0};
    tbl[1] = '{4'b0111, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 5'd4, 1'b0, 1'b1, 4'b0011, 16'd1, 16'd1};
    tbl[2] = '{4'b0111, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 4'b0000, 16'd2, 16'd1};
    tbl[3] = '{4'b0111, 5'd6, 5'd7, 5'd6, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 4'b1100, 16'd2, 16'd1};
    tbl[4] = '{4'b0111, 5'd6, 5'd9, 5'd1, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 4'b1100, 16'd2, 16'd1};
    tbl[5] = '{4'b0111, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 4'b0011, 16'd3, 16'd2};
    tbl[6] = '{4'b0111, 5'd8, 5'd10, 5'd10, 1'b0, 1'b0, 5'd8, 1'b0, 1'b1, 4'b0011, 16'd4, 16'd3};
    tbl[7] = '{4'b0111, 5'd11, 5'd13, 5'd12, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0, 4'b0000, 16'd5, 16'd3};
    tbl[8] = '{4'b0110, 5'd6, 5'd1, 5'd6, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 4'b0000, 16'd5, 16'd3};
    tbl[9] = '{4'b0111, 5'd0, 5'd3, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b1, 4'b0011, 16'd6, 16'd4};

    // Reset: outputs forced low even with a resolvable taken branch presented
    bif.start_i = 1'b0;
    set_in(4'b0111, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 5'd4, 1'b0, 1'b1);
    #2;
    chk("rst_outs", {12'd0, outs()}, 16'd0);
    cnt_chk("rst", 16'd0, 16'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    cyc_chk("idle_0", 4'b0000);
    cyc_chk("idle_1", 4'b0000);
    cnt_chk("idle", 16'd0, 16'd0);
    start_run();

    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].ex_rd, tbl[i].ex_rw, tbl[i].ex_mr,
             tbl[i].mem_rd, tbl[i].mem_mr, tbl[i].eq);
      cyc_chk($sformatf("vec%0d_outs", i), tbl[i].exp_o);
      cnt_chk($sformatf("vec%0d", i), tbl[i].exp_b, tbl[i].exp_t);
    end

    // ALU-result hazard on rt: one stall, then resolve not-taken
    set_in(4'b0111, 5'd2, 5'd7, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc_chk("alu_stall", 4'b1100);
    set_in(4'b0111, 5'd2, 5'd7, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc_chk("alu_resolve", 4'b0000);
    cnt_chk("alu", 16'd7, 16'd4);

    // EX load and MEM load together: the two-cycle stall must win
    set_in(4'b0111, 5'd5, 5'd9, 5'd5, 1'b0, 1'b1, 5'd9, 1'b1, 1'b1);
    cyc_chk("prio_c1", 4'b1100);
    set_in(4'b0111, 5'd5, 5'd9, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    cyc_chk("prio_c2", 4'b1100);
    cnt_chk("prio_mid", 16'd7, 16'd4);
    cyc_chk("prio_c3", 4'b0011);
    cnt_chk("prio", 16'd8, 16'd5);

    // Reset in the middle of a load stall
    set_in(4'b0111, 5'd5, 5'd1, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1);
    cyc_chk("rst_mid_c1", 4'b1100);
    #1;
    rst_i = 1'b0;
    #1;
    chk("rst_mid_outs", {12'd0, outs()}, 16'd0);
    cnt_chk("rst_mid", 16'd0, 16'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    set_in(4'b0111, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 5'd4, 1'b0, 1'b1);
    cyc_chk("post_rst_idle0", 4'b0000);
    cyc_chk("post_rst_idle1", 4'b0000);
    cnt_chk("post_rst", 16'd0, 16'd0);
    start_run();

    // Load-use hazard on rs: exactly two stall cycles, WAIT1 ignores inputs
    set_in(4'b0111, 5'd5, 5'd1, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1);
    cyc_chk("load_c1", 4'b1100);
    cyc_chk("load_c2", 4'b1100);
    cnt_chk("load_mid", 16'd0, 16'd0);
    set_in(4'b0111, 5'd5, 5'd1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    bif.start_i = 1'b1;
    cyc_chk("load_c3", 4'b0011);
    bif.start_i = 1'b0;
    cnt_chk("load", 16'd1, 16'd1);

    // Saturation: reset, then 65535 taken resolves, then one more
    rst_i = 1'b0;
    #1;
    rst_i = 1'b1;
    start_run();
    set_in(4'b0111, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 5'd4, 1'b0, 1'b1);
    repeat (65535) @(posedge clk_i);
    #1;
    cnt_chk("sat_full", 16'hFFFF, 16'hFFFF);
    cyc_chk("sat_extra", 4'b0011);
    cnt_chk("sat_hold", 16'hFFFF, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
